uart_cmd_controller: RTL and testbench

Sequences the 8-bit UART receiver and turns its byte stream into two-byte commands (command code, then sensor address) for the sensor-control logic. It owns the receiver's `en` line and restarts the receiver after a receive error. It validates each byte, enforces an inter-byte timeout, and presents completed commands on a valid/ready handshake. It also counts protocol faults.

---
 rtl/uart_cmd_controller.sv | 190 +++++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_controller.sv
// Purpose : turns the UART receiver byte stream into two-byte commands (code, then address),
//           owns the receiver enable, restarts it after a receive error, counts protocol faults.
// Latency : every output is registered, one cycle after the triggering input edge.
// Backpressure: a held command waits for cmd_ready; bytes arriving meanwhile are dropped (overrun).
// Ports   : clk/rst (sync, active-high); rx_data/rx_done/rx_err/rx_en to the receiver;
//           cmd_valid/cmd_ready/cmd_code/cmd_addr command handshake;
//           frame_err/timeout/overrun/rx_fault fault pulses; err_count saturating fault count.
module uart_cmd_controller #(
    parameter int unsigned TIMEOUT  = 320,
    parameter int unsigned RECOVERY = 2,
    parameter logic [7:0]  MAX_CMD  = 8'h07,
    parameter logic [7:0]  MAX_ADDR = 8'h1F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic       rx_en,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_addr,
    output logic       frame_err,
    output logic       timeout,
    output logic       overrun,
    output logic       rx_fault,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RECOVERY + 1);
    // Timer is cleared on the accepting edge, so it holds TIMEOUT-1 on the edge that is
    // TIMEOUT cycles later; that edge still accepts an address, otherwise it times out.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REC_LAST   = RW'(RECOVERY - 1);

    typedef enum logic [1:0] {
        RECOVER   = 2'd0,
        WAIT_CMD  = 2'd1,
        WAIT_ADDR = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    code_q, code_d;
    logic          rx_en_q, rx_en_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_code_q, cmd_code_d;
    logic [7:0]    cmd_addr_q, cmd_addr_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          rx_fault_q, rx_fault_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          byte_as_cmd;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        timer_d     = timer_q;
        code_d      = code_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_addr_d  = cmd_addr_q;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;
        rx_fault_d  = 1'b0;
        byte_as_cmd = 1'b0;

        if (state_q == RECOVER) begin
            // Receiver held disabled; rx_err and rx_done are ignored here so a
            // long rx_err produces one fault per recovery, not one per cycle.
            if (rcnt_q == REC_LAST) begin
                state_d = WAIT_CMD;
                rcnt_d  = '0;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end else if (rx_err) begin
            rx_fault_d  = 1'b1;
            state_d     = RECOVER;
            rcnt_d      = '0;
            cmd_valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_CMD: begin
                    byte_as_cmd = rx_done;
                end
                WAIT_ADDR: begin
                    if (rx_done) begin
                        if (rx_data <= MAX_ADDR) begin
                            cmd_code_d  = code_q;
                            cmd_addr_d  = rx_data;
                            cmd_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_CMD;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = WAIT_CMD;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (cmd_ready) begin
                        // Handshake frees the slot this cycle, so a coincident byte
                        // is a fresh command byte rather than an overrun.
                        cmd_valid_d = 1'b0;
                        state_d     = WAIT_CMD;
                        byte_as_cmd = rx_done;
                    end else if (rx_done) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = RECOVER;
                end
            endcase

            if (byte_as_cmd) begin
                if (rx_data <= MAX_CMD) begin
                    code_d  = rx_data;
                    timer_d = '0;
                    state_d = WAIT_ADDR;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_CMD;
                end
            end
        end

        rx_en_d = (state_d != RECOVER);

        // One count per cycle however many faults coincide.
        err_count_d = err_count_q;
        if ((frame_err_d || timeout_d || overrun_d || rx_fault_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RECOVER;
            rcnt_q      <= '0;
            timer_q     <= '0;
            code_q      <= '0;
            rx_en_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_addr_q  <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rx_fault_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            timer_q     <= timer_d;
            code_q      <= code_d;
            rx_en_q     <= rx_en_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_addr_q  <= cmd_addr_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            rx_fault_q  <= rx_fault_d;
            err_count_q <= err_count_d;
        end
    end

    assign rx_en     = rx_en_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_addr  = cmd_addr_q;
    assign frame_err = frame_err_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;
    assign rx_fault  = rx_fault_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Purpose : self-checking bench for uart_cmd_controller: vector table, corner sequences, random traffic.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next edge.
// Backpressure: cmd_ready driven from tables, sequences and random stimulus.
module tb_uart_cmd_controller;

    localparam int TIMEOUT  = 320;
    localparam int RECOVERY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic       rx_en;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [7:0] cmd_code;
    logic [7:0] cmd_addr;
    logic       frame_err;
    logic       timeout;
    logic       overrun;
    logic       rx_fault;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_cmd_controller #(
        .TIMEOUT (TIMEOUT),
        .RECOVERY(RECOVERY),
        .MAX_CMD (8'h07),
        .MAX_ADDR(8'h1F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .rx_en    (rx_en),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_code (cmd_code),
        .cmd_addr (cmd_addr),
        .frame_err(frame_err),
        .timeout  (timeout),
        .overrun  (overrun),
        .rx_fault (rx_fault),
        .err_count(err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge-stamped bookkeeping instead of counters.
    int          edge_no   = 0;
    int          rx_en_at  = 0;      // edge after which the receiver is enabled again
    bit          have_code = 1'b0;
    int          code_edge = 0;      // edge on which the pending command byte was accepted
    logic [7:0]  pend_code = 8'h00;
    logic [15:0] held[$];            // command waiting for the consumer
    logic [7:0]  m_code = 8'h00, m_addr = 8'h00, m_err = 8'h00;
    bit          m_ferr, m_tout, m_ovr, m_flt;

    typedef struct {
        bit         rst, err, done;
        logic [7:0] dat;
        bit         rdy;
        bit         en, vld;
        logic [3:0] pul;   // {frame_err, timeout, overrun, rx_fault}
        logic [7:0] code, addr, cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit e, bit d, logic [7:0] dat, bit rdy,
                               bit en, bit vld, logic [3:0] pul,
                               logic [7:0] code, logic [7:0] addr, logic [7:0] cnt);
        vec_t x;
        x.rst = r; x.err = e; x.done = d; x.dat = dat; x.rdy = rdy;
        x.en = en; x.vld = vld; x.pul = pul; x.code = code; x.addr = addr; x.cnt = cnt;
        return x;
    endfunction

    function automatic logic [29:0] dut_vec();
        return {rx_en, cmd_valid, frame_err, timeout, overrun, rx_fault, cmd_code, cmd_addr, err_count};
    endfunction

    function automatic logic [29:0] model_vec();
        return {(edge_no >= rx_en_at), (held.size() != 0), m_ferr, m_tout, m_ovr, m_flt,
                m_code, m_addr, m_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit er, input bit dn, input logic [7:0] dat, input bit rdy);
        bit byte_as_cmd;
        byte_as_cmd = 1'b0;
        m_ferr = 1'b0; m_tout = 1'b0; m_ovr = 1'b0; m_flt = 1'b0;
        if (r) begin
            rx_en_at  = edge_no + RECOVERY;
            have_code = 1'b0;
            held.delete();
            m_code = 8'h00; m_addr = 8'h00; m_err = 8'h00;
            return;
        end
        if (edge_no > rx_en_at) begin
            if (er) begin
                m_flt     = 1'b1;
                have_code = 1'b0;
                held.delete();
                rx_en_at  = edge_no + RECOVERY;
            end else if (held.size() != 0) begin
                if (rdy) begin
                    void'(held.pop_front());
                    byte_as_cmd = dn;
                end else if (dn) begin
                    m_ovr = 1'b1;
                end
            end else if (have_code) begin
                if (dn) begin
                    have_code = 1'b0;
                    if (dat <= 8'h1F) begin
                        held.push_back({pend_code, dat});
                        m_code = pend_code;
                        m_addr = dat;
                    end else begin
                        m_ferr = 1'b1;
                    end
                end else if (edge_no - code_edge >= TIMEOUT) begin
                    have_code = 1'b0;
                    m_tout    = 1'b1;
                end
            end else begin
                byte_as_cmd = dn;
            end
            if (byte_as_cmd) begin
                if (dat <= 8'h07) begin
                    have_code = 1'b1;
                    pend_code = dat;
                    code_edge = edge_no;
                end else begin
                    m_ferr = 1'b1;
                end
            end
        end
        if (m_ferr || m_tout || m_ovr || m_flt)
            m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare every output.
    task automatic step(input bit r, input bit er, input bit dn, input logic [7:0] dat, input bit rdy);
        rst = r; rx_err = er; rx_done = dn; rx_data = dat; cmd_ready = rdy;
        @(posedge clk);
        #1;
        edge_no++;
        model(r, er, dn, dat, rdy);
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        vec_t x;
        bit   seen;
        int   faults;

        //                rst err dn dat   rdy  en vld pul    code   addr   cnt
        tbl.push_back(v(1, 0, 0, 8'h00, 0,   0, 0, 4'h0, 8'h00, 8'h00, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   0, 0, 4'h0, 8'h00, 8'h00, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   1, 0, 4'h0, 8'h00, 8'h00, 8'h00));
        tbl.push_back(v(0, 0, 1, 8'h03, 0,   1, 0, 4'h0, 8'h00, 8'h00, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   1, 0, 4'h0, 8'h00, 8'h00, 8'h00));
        tbl.push_back(v(0, 0, 1, 8'h11, 1,   1, 1, 4'h0, 8'h03, 8'h11, 8'h00));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 0, 4'h0, 8'h03, 8'h11, 8'h00));
        tbl.push_back(v(0, 0, 1, 8'h09, 0,   1, 0, 4'h8, 8'h03, 8'h11, 8'h01));
        tbl.push_back(v(0, 0, 1, 8'h02, 0,   1, 0, 4'h0, 8'h03, 8'h11, 8'h01));
        tbl.push_back(v(0, 0, 1, 8'h40, 0,   1, 0, 4'h8, 8'h03, 8'h11, 8'h02));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   1, 0, 4'h0, 8'h03, 8'h11, 8'h02));
        tbl.push_back(v(0, 0, 1, 8'h04, 0,   1, 0, 4'h0, 8'h03, 8'h11, 8'h02));
        tbl.push_back(v(0, 0, 1, 8'h02, 0,   1, 1, 4'h0, 8'h04, 8'h02, 8'h02));
        tbl.push_back(v(0, 0, 1, 8'h01, 0,   1, 1, 4'h2, 8'h04, 8'h02, 8'h03));
        tbl.push_back(v(0, 0, 1, 8'h07, 1,   1, 0, 4'h0, 8'h04, 8'h02, 8'h03));
        tbl.push_back(v(0, 0, 1, 8'h1F, 0,   1, 1, 4'h0, 8'h07, 8'h1F, 8'h03));
        tbl.push_back(v(0, 0, 0, 8'h00, 1,   1, 0, 4'h0, 8'h07, 8'h1F, 8'h03));
        tbl.push_back(v(0, 0, 1, 8'h01, 0,   1, 0, 4'h0, 8'h07, 8'h1F, 8'h03));
        tbl.push_back(v(0, 1, 1, 8'h05, 0,   0, 0, 4'h1, 8'h07, 8'h1F, 8'h04));
        tbl.push_back(v(0, 1, 0, 8'h00, 0,   0, 0, 4'h0, 8'h07, 8'h1F, 8'h04));
        tbl.push_back(v(0, 0, 1, 8'h03, 0,   1, 0, 4'h0, 8'h07, 8'h1F, 8'h04));
        tbl.push_back(v(0, 0, 1, 8'h05, 0,   1, 0, 4'h0, 8'h07, 8'h1F, 8'h04));
        tbl.push_back(v(0, 0, 1, 8'h06, 0,   1, 1, 4'h0, 8'h05, 8'h06, 8'h04));
        tbl.push_back(v(0, 1, 0, 8'h00, 1,   0, 0, 4'h1, 8'h05, 8'h06, 8'h05));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   0, 0, 4'h0, 8'h05, 8'h06, 8'h05));
        tbl.push_back(v(0, 0, 0, 8'h00, 0,   1, 0, 4'h0, 8'h05, 8'h06, 8'h05));

        for (int i = 0; i < tbl.size(); i++) begin
            x = tbl[i];
            step(x.rst, x.err, x.done, x.dat, x.rdy);
            check($sformatf("table_row%0d", i), 32'(dut_vec()),
                  32'({x.en, x.vld, x.pul, x.code, x.addr, x.cnt}));
        end

        // Timeout fires exactly TIMEOUT edges after the command byte is accepted.
        step(0, 0, 1, 8'h01, 0);
        seen = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            step(0, 0, 0, 8'h00, 0);
            seen = seen | timeout;
        end
        check("early_timeout", 32'(seen), 32'd0);
        step(0, 0, 0, 8'h00, 0);
        check("timeout_pulse", 32'(timeout), 32'd1);
        check("timeout_count", 32'(err_count), 32'h06);
        step(0, 0, 1, 8'h05, 0);
        step(0, 0, 1, 8'h00, 0);
        check("after_timeout_cmd", 32'({cmd_valid, cmd_code, cmd_addr}), 32'h1_05_00);
        step(0, 0, 0, 8'h00, 1);

        // Address arriving on the last allowed edge is still accepted.
        step(0, 0, 1, 8'h02, 0);
        idle(TIMEOUT - 1);
        step(0, 0, 1, 8'h1A, 0);
        check("late_addr_accept", 32'({cmd_valid, timeout, cmd_code, cmd_addr}), 32'h2_02_1A);
        step(0, 0, 0, 8'h00, 1);

        // rx_err held high: one fault per recovery window.
        faults = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 8'h00, 0);
            faults += int'(rx_fault);
        end
        check("held_rx_err_faults", 32'(faults), 32'd2);
        idle(1);
        check("held_rx_err_enable", 32'(rx_en), 32'd1);

        // Saturation of the fault counter.
        for (int k = 0; k < 300; k++) step(0, 0, 1, 8'hFF, 0);
        check("err_saturate", 32'({frame_err, err_count}), 32'h1FF);

        // Reset mid-frame and during a held command.
        step(0, 0, 1, 8'h03, 0);
        step(1, 0, 1, 8'h04, 0);
        check("reset_mid_frame", 32'(dut_vec()), 32'd0);
        idle(2);
        step(0, 0, 1, 8'h03, 0);
        step(0, 0, 1, 8'h04, 0);
        check("hold_before_reset", 32'({cmd_valid, cmd_code, cmd_addr}), 32'h1_03_04);
        step(1, 1, 1, 8'hFF, 0);
        check("reset_in_hold", 32'(dut_vec()), 32'd0);
        idle(2);

        // Dense random traffic.
        for (int k = 0; k < 4000; k++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 47));
            step($urandom_range(0, 255) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 3, d, $urandom_range(0, 9) < 4);
        end
        // Sparse traffic so address gaps exceed the timeout.
        for (int k = 0; k < 4000; k++) begin
            step(1'b0, $urandom_range(0, 999) == 0, $urandom_range(0, 199) == 0,
                 8'($urandom_range(0, 40)), $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
